// File: rtl/inst_sram_fetch.sv
// Instruction-fetch responder. It takes the fetch address from the PC register
// and reads the external base SRAM with WAIT_CYCLES extra read cycles. It then
// hands the instruction and its address to IF/ID. While a fetch is in
// progress, stall_req_o holds the PC register.
//
// state | meaning
// IDLE  | no access; SRAM deselected
// BUSY  | SRAM read in progress; r_cnt counts remaining wait cycles
// DONE  | inst_o/inst_pc_o valid for this one cycle; may accept next fetch
module inst_sram_fetch #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc_i,
  input  logic              ce_i,
  input  logic              flush_i,
  output logic [31:0]       inst_o,
  output logic [31:0]       inst_pc_o,
  output logic              inst_valid_o,
  output logic              addr_err_o,
  output logic              stall_req_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic [3:0]        sram_be_n_o,
  input  logic [31:0]       sram_data_i
);

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr_q;
  logic        w_accept;
  logic        w_misaligned;
  logic        w_capture;
  logic        w_stall;

  assign w_misaligned = |pc_i[1:0];

  // Next-state, accept and stall decode; flush outranks everything but rst.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (ce_i && !flush_i) begin
          w_accept    = 1'b1;
          w_stall     = 1'b1;
          w_state_nxt = w_misaligned ? DONE : BUSY;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (flush_i) begin
          w_state_nxt = IDLE;
        end else if (r_cnt != 4'd0) begin
          w_stall = 1'b1;
        end else begin
          // Releasing the stall here lets the PC advance on the same edge
          // that captures the data, so the next request is ready in DONE.
          w_capture   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (rst) begin
      w_state_nxt = IDLE;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_stall     = 1'b0;
    end
  end

  assign stall_req_o  = w_stall;
  assign inst_valid_o = (r_state == DONE);
  assign sram_we_n_o  = 1'b1;

  // State register, wait counter and latched fetch address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_addr_q <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr_q <= pc_i;
        r_cnt    <= LP_WAIT;
      end else if (r_state == BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Result registers: an SRAM word on completion, or an error for a misaligned PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_o     <= 32'd0;
      inst_pc_o  <= 32'd0;
      addr_err_o <= 1'b0;
    end else if (w_accept && w_misaligned) begin
      inst_o     <= 32'd0;
      inst_pc_o  <= pc_i;
      addr_err_o <= 1'b1;
    end else if (w_capture) begin
      inst_o     <= sram_data_i;
      inst_pc_o  <= r_addr_q;
      addr_err_o <= 1'b0;
    end
  end

  // SRAM strobes are registered from the next state so they are clean for all of BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_addr_o <= '0;
      sram_ce_n_o <= 1'b1;
      sram_oe_n_o <= 1'b1;
      sram_be_n_o <= 4'hF;
    end else begin
      sram_ce_n_o <= (w_state_nxt != BUSY);
      sram_oe_n_o <= (w_state_nxt != BUSY);
      sram_be_n_o <= (w_state_nxt == BUSY) ? 4'h0 : 4'hF;
      if (w_accept && !w_misaligned) begin
        sram_addr_o <= pc_i[ADDR_W+1:2];
      end
    end
  end

endmodule

// File: tb/tb_inst_sram_fetch.sv
// Directed bench for inst_sram_fetch with WAIT_CYCLES=2. A per-cycle vector
// table covers reset, a single fetch, a misaligned fetch and flush. Streaming
// and reset mid-access are run as hand-written sequences.
module tb_inst_sram_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i;
  logic        flush_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        addr_err_o;
  logic        stall_req_o;
  logic [19:0] sram_addr_o;
  logic        sram_ce_n_o;
  logic        sram_oe_n_o;
  logic        sram_we_n_o;
  logic [3:0]  sram_be_n_o;
  logic [31:0] sram_data_i;

  int n_checks = 0;
  int n_fail   = 0;

  inst_sram_fetch #(.WAIT_CYCLES(2), .ADDR_W(20)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i), .flush_i(flush_i),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o),
    .addr_err_o(addr_err_o), .stall_req_o(stall_req_o),
    .sram_addr_o(sram_addr_o), .sram_ce_n_o(sram_ce_n_o),
    .sram_oe_n_o(sram_oe_n_o), .sram_we_n_o(sram_we_n_o),
    .sram_be_n_o(sram_be_n_o), .sram_data_i(sram_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ce;
    logic        flush;
    logic [31:0] pc;
    logic [31:0] data;
    logic        stall;
    logic        valid;
    logic        ce_n;
    logic [19:0] addr;
    logic [31:0] inst;
    logic [31:0] ipc;
    logic        err;
  } vec_t;

  localparam int NV = 21;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic r, input logic c, input logic f,
                              input logic [31:0] p, input logic [31:0] d,
                              input logic s, input logic v, input logic cn,
                              input logic [19:0] a, input logic [31:0] in,
                              input logic [31:0] ip, input logic e);
    vec_t t;
    t.rst = r; t.ce = c; t.flush = f; t.pc = p; t.data = d;
    t.stall = s; t.valid = v; t.ce_n = cn; t.addr = a;
    t.inst = in; t.ipc = ip; t.err = e;
    return t;
  endfunction

  function automatic logic [31:0] sram_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] model_pc;
    logic [31:0] exp_pcs[3];
    int nvalid;
    int last_c;
    int lat;

    // cycle-by-cycle table: inputs during the cycle, outputs expected in that cycle
    vecs[0]  = mk(1,1,0,32'h8000_0010,JUNK, 0,0,1,20'h0,0,0,0);
    vecs[1]  = mk(1,1,0,32'h8000_0010,JUNK, 0,0,1,20'h0,0,0,0);
    vecs[2]  = mk(0,1,0,32'h8000_0010,JUNK, 1,0,1,20'h0,0,0,0);
    vecs[3]  = mk(0,1,0,32'h8000_0010,JUNK, 1,0,0,20'h00004,0,0,0);
    vecs[4]  = mk(0,1,0,32'h8000_0010,JUNK, 1,0,0,20'h00004,0,0,0);
    vecs[5]  = mk(0,0,0,32'h8000_0010,32'h3C01_8000, 0,0,0,20'h00004,0,0,0);
    vecs[6]  = mk(0,0,0,32'h8000_0010,JUNK, 0,1,1,20'h0,32'h3C01_8000,32'h8000_0010,0);
    vecs[7]  = mk(0,0,0,32'h0,JUNK, 0,0,1,20'h0,0,0,0);
    vecs[8]  = mk(0,1,0,32'h8000_0002,JUNK, 1,0,1,20'h0,0,0,0);
    vecs[9]  = mk(0,0,0,32'h8000_0002,JUNK, 0,1,1,20'h0,32'h0,32'h8000_0002,1);
    vecs[10] = mk(0,0,0,32'h0,JUNK, 0,0,1,20'h0,0,0,0);
    vecs[11] = mk(0,1,0,32'h8000_0020,JUNK, 1,0,1,20'h0,0,0,0);
    vecs[12] = mk(0,1,0,32'h8000_0020,JUNK, 1,0,0,20'h00008,0,0,0);
    vecs[13] = mk(0,1,1,32'h8000_0020,JUNK, 0,0,0,20'h00008,0,0,0);
    vecs[14] = mk(0,1,1,32'h8000_0040,JUNK, 0,0,1,20'h0,0,0,0);
    vecs[15] = mk(0,1,0,32'h8000_0040,JUNK, 1,0,1,20'h0,0,0,0);
    vecs[16] = mk(0,1,0,32'h8000_0040,JUNK, 1,0,0,20'h00010,0,0,0);
    vecs[17] = mk(0,1,0,32'h8000_0040,JUNK, 1,0,0,20'h00010,0,0,0);
    vecs[18] = mk(0,1,0,32'h8000_0040,32'h1234_5678, 0,0,0,20'h00010,0,0,0);
    vecs[19] = mk(0,1,1,32'h8000_0044,JUNK, 0,1,1,20'h0,32'h1234_5678,32'h8000_0040,0);
    vecs[20] = mk(0,0,0,32'h8000_0044,JUNK, 0,0,1,20'h0,0,0,0);

    rst = 1'b1; ce_i = 1'b1; flush_i = 1'b0; pc_i = 32'h8000_0010; sram_data_i = JUNK;
    @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; ce_i = vecs[i].ce; flush_i = vecs[i].flush;
      pc_i = vecs[i].pc; sram_data_i = vecs[i].data;
      #1;
      chk($sformatf("v%0d stall", i), 32'(stall_req_o), 32'(vecs[i].stall));
      chk($sformatf("v%0d valid", i), 32'(inst_valid_o), 32'(vecs[i].valid));
      chk($sformatf("v%0d ce_n", i), 32'(sram_ce_n_o), 32'(vecs[i].ce_n));
      chk($sformatf("v%0d oe_n", i), 32'(sram_oe_n_o), 32'(vecs[i].ce_n));
      chk($sformatf("v%0d be_n", i), 32'(sram_be_n_o), vecs[i].ce_n ? 32'hF : 32'h0);
      chk($sformatf("v%0d we_n", i), 32'(sram_we_n_o), 32'h1);
      if (!vecs[i].ce_n)
        chk($sformatf("v%0d addr", i), 32'(sram_addr_o), 32'(vecs[i].addr));
      if (vecs[i].valid) begin
        chk($sformatf("v%0d inst", i), inst_o, vecs[i].inst);
        chk($sformatf("v%0d inst_pc", i), inst_pc_o, vecs[i].ipc);
        chk($sformatf("v%0d addr_err", i), 32'(addr_err_o), 32'(vecs[i].err));
      end
    end

    // streaming: PC register model advances only when stall_req_o is low
    exp_pcs[0] = 32'h8000_0000; exp_pcs[1] = 32'h8000_0004; exp_pcs[2] = 32'h8000_0008;
    model_pc = 32'h8000_0000;
    nvalid = 0;
    last_c = 0;
    for (int c = 0; c < 40 && nvalid < 3; c++) begin
      @(negedge clk);
      rst = 1'b0; flush_i = 1'b0; ce_i = 1'b1;
      pc_i = model_pc; sram_data_i = sram_word(model_pc);
      #1;
      if (inst_valid_o) begin
        chk($sformatf("stream%0d inst_pc", nvalid), inst_pc_o, exp_pcs[nvalid]);
        chk($sformatf("stream%0d inst", nvalid), inst_o, sram_word(exp_pcs[nvalid]));
        chk($sformatf("stream%0d interval", nvalid), 32'(c - last_c), 32'd4);
        last_c = c;
        nvalid++;
      end
      if (!stall_req_o) model_pc = model_pc + 32'd4;
    end
    chk("stream count", 32'(nvalid), 32'd3);

    ce_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      ce_i = 1'b0; sram_data_i = sram_word(pc_i);
    end
    #1;
    chk("drain valid", 32'(inst_valid_o), 32'h0);
    chk("drain stall", 32'(stall_req_o), 32'h0);

    // reset in the middle of an access
    @(negedge clk);
    ce_i = 1'b1; pc_i = 32'h8000_0000; sram_data_i = JUNK;
    #1;
    chk("rstmid accept stall", 32'(stall_req_o), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid stall forced", 32'(stall_req_o), 32'h0);
    @(negedge clk);
    rst = 1'b0; ce_i = 1'b0;
    #1;
    chk("rstmid ce_n", 32'(sram_ce_n_o), 32'h1);
    chk("rstmid oe_n", 32'(sram_oe_n_o), 32'h1);
    chk("rstmid be_n", 32'(sram_be_n_o), 32'hF);
    chk("rstmid addr", 32'(sram_addr_o), 32'h0);
    chk("rstmid valid", 32'(inst_valid_o), 32'h0);
    chk("rstmid stall", 32'(stall_req_o), 32'h0);
    chk("rstmid inst", inst_o, 32'h0);
    chk("rstmid inst_pc", inst_pc_o, 32'h0);

    lat = -1;
    model_pc = 32'h8000_0000;
    for (int c = 0; c < 10 && lat < 0; c++) begin
      @(negedge clk);
      ce_i = (model_pc == 32'h8000_0000);
      pc_i = model_pc; sram_data_i = sram_word(32'h8000_0000);
      #1;
      if (inst_valid_o) begin
        lat = c;
        chk("refetch inst", inst_o, sram_word(32'h8000_0000));
        chk("refetch inst_pc", inst_pc_o, 32'h8000_0000);
      end
      if (!stall_req_o) model_pc = model_pc + 32'd4;
    end
    chk("refetch latency", 32'(lat), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_sram_fetch.md
Name: inst_sram_fetch

Overview:
- Responder side of the instruction-fetch interface: accepts the fetch address/enable pair driven by the IF-stage PC register.
- Performs the read on the external base SRAM with a configurable number of wait states.
- Returns the instruction word with its address to IF/ID.
- Asserts a stall request so the PC register holds its address until the fetch completes.

Parameters:
- WAIT_CYCLES, 2: extra SRAM read cycles per access (0..15).
- ADDR_W, 20: SRAM word-address width; word address = pc_i[ADDR_W+1:2].

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pc_i  in  32  fetch address from PC register
- ce_i  in  1  fetch enable from PC register
- flush_i  in  1  abort the in-flight fetch (branch/exception redirect)
- inst_o  out  32  fetched instruction
- inst_pc_o  out  32  address of inst_o
- inst_valid_o  out  1  inst_o/inst_pc_o valid this cycle
- addr_err_o  out  1  fetch address misaligned (qualified by inst_valid_o)
- stall_req_o  out  1  hold the PC register this cycle (combinational)
- sram_addr_o  out  ADDR_W  SRAM word address
- sram_ce_n_o  out  1  SRAM chip enable, active-low
- sram_oe_n_o  out  1  SRAM output enable, active-low
- sram_we_n_o  out  1  SRAM write enable, active-low; tied high
- sram_be_n_o  out  4  SRAM byte enables, active-low
- sram_data_i  in  32  SRAM read data

Behaviour:
- Reset values (rst high):
  - state=IDLE, cnt=0, addr_q=0.
  - inst_o=0, inst_pc_o=0, inst_valid_o=0, addr_err_o=0.
  - sram_addr_o=0, sram_ce_n_o=1, sram_oe_n_o=1, sram_we_n_o=1, sram_be_n_o=4'hF.
  - stall_req_o forced 0.
  - A reset mid-access abandons the access; nothing is delivered.
- States: IDLE, BUSY, DONE.
- Accept condition: state is IDLE or DONE, ce_i=1, flush_i=0. On accept:
  - stall_req_o=1 in that cycle.
  - addr_q<=pc_i.
  - Aligned (pc_i[1:0]==0): cnt<=WAIT_CYCLES, next state BUSY.
  - Misaligned: no SRAM access, next state DONE with inst_o<=0, inst_pc_o<=pc_i, addr_err_o<=1.
- BUSY, SRAM signals (registered):
  - sram_ce_n_o=0, sram_oe_n_o=0, sram_be_n_o=4'h0.
  - sram_addr_o=addr_q[ADDR_W+1:2], stable for the whole BUSY period.
- BUSY, cnt!=0: stall_req_o=1, cnt<=cnt-1.
- BUSY, cnt==0:
  - stall_req_o=0, so the PC advances at this edge.
  - inst_o<=sram_data_i, inst_pc_o<=addr_q, addr_err_o<=0, next state DONE.
- DONE:
  - inst_valid_o=1 for exactly one cycle.
  - SRAM deselected unless a new access starts.
  - If the accept condition holds, accept the new pc_i (back-to-back); otherwise go to IDLE.
- IDLE with ce_i=0: stall_req_o=0, SRAM deselected, inst_valid_o=0.
- Latency and throughput:
  - Aligned fetch: accept cycle to inst_valid_o = WAIT_CYCLES+2 cycles.
  - Sustained rate: one instruction per WAIT_CYCLES+2 cycles.
  - Misaligned fetch: inst_valid_o on the next cycle.
- flush_i:
  - Highest priority below rst; stall_req_o=0 in the flush cycle.
  - In BUSY: access aborted, next state IDLE, SRAM deselected next cycle, no inst_valid_o.
  - In DONE: inst_valid_o still reported this cycle (IF/ID discards it on flush), no accept.
  - With ce_i=1 in the same cycle: no accept; the request is taken on the following cycle.
- cnt is 4 bits; WAIT_CYCLES>15 is illegal.
- pc_i must stay stable while stall_req_o=1 (guaranteed by the PC register's stall priority). Changes during BUSY are ignored because addr_q is used.
- sram_data_i is sampled only on the BUSY cnt==0 edge.

Test Plan:
- Reset: rst high 2 cycles with ce_i=1 -> sram_ce_n_o=1, sram_oe_n_o=1, sram_we_n_o=1, sram_be_n_o=4'hF, stall_req_o=0, inst_valid_o=0.
- Single fetch, WAIT_CYCLES=2: pc_i=0x8000_0010, ce_i=1, sram_data_i=0x3C01_8000 ->
  - sram_addr_o=0x00004.
  - stall_req_o=1 cycles 0-2, 0 in cycle 3.
  - Cycle 4: inst_valid_o=1, inst_o=0x3C01_8000, inst_pc_o=0x8000_0010.
- Streaming: PC model from 0x8000_0000 honouring stall_req_o ->
  - inst_valid_o every 4 cycles, inst_pc_o 0x8000_0000, 0x8000_0004, 0x8000_0008.
  - No address skipped or repeated.
- Misaligned: pc_i=0x8000_0002 -> sram_ce_n_o stays 1, stall_req_o=1 for one cycle; next cycle inst_valid_o=1, addr_err_o=1, inst_o=0.
- Flush: flush_i=1 while BUSY with cnt=1 -> next cycle IDLE, sram_ce_n_o=1, no inst_valid_o for that address; a new pc_i is accepted the cycle after flush drops.
- Reset mid-access: rst high during BUSY -> next cycle all outputs at reset values, no inst_valid_o; after release a fetch of 0x8000_0000 completes normally in 4 cycles.
